// File: rtl/seq_mult_32.sv
// Iterative shift-add 32x32 unsigned multiplier built around one shared adder_32 ripple adder.
// Optional signed mode (two's-complement operands) is enabled by defining SEQ_MULT_SIGNED_EN.

module adder_32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        CarryIn,
    output logic [31:0] S
);
    logic carry;

    always_comb begin
        carry = CarryIn;
        S     = '0;
        for (int i = 0; i < 32; i++) begin
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
    end
endmodule

// Handshake: start is the request valid and ~busy is ready; an operation is accepted on a
// rising edge where start=1 and busy=0. done pulses for one cycle with the product valid.
module seq_mult_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic [2:0]       dbgState
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        DONE   = 3'd2
`ifdef SEQ_MULT_SIGNED_EN
        ,
        ABS_A  = 3'd3,
        ABS_B  = 3'd4,
        NEG_LO = 3'd5,
        NEG_HI = 3'd6
`endif
    } stateT;

    stateT              state, stateNext;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] product;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   adderA, adderB, adderS;
    logic               adderCin;
    logic               carryOut;
    logic               lastIter;
    logic               runToDone;
    logic [2*WIDTH-1:0] runAcc;

`ifdef SEQ_MULT_SIGNED_EN
    logic signedOp, negSign, loWasZero;
    assign runToDone = ~signedOp;
`else
    assign runToDone = 1'b1;
`endif

    adder_32 uAdder (
        .A       (adderA),
        .B       (adderB),
        .CarryIn (adderCin),
        .S       (adderS)
    );

    // adder_32 has no carry output, so recover it from the operand and sum MSBs.
    assign carryOut = (adderA[WIDTH-1] & adderB[WIDTH-1]) |
                      ((adderA[WIDTH-1] | adderB[WIDTH-1]) & ~adderS[WIDTH-1]);
    assign runAcc   = {carryOut, adderS, acc[WIDTH-1:1]};
    assign lastIter = (cnt == CNT_W'(WIDTH - 1));

    assign product_hi = product[2*WIDTH-1:WIDTH];
    assign product_lo = product[WIDTH-1:0];
    assign dbgState   = state;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        adderA    = '0;
        adderB    = '0;
        adderCin  = 1'b0;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
`ifdef SEQ_MULT_SIGNED_EN
                    stateNext = is_signed ? ABS_A : RUN;
`else
                    stateNext = RUN;
`endif
                end
            end
            RUN: begin
                adderA = acc[2*WIDTH-1:WIDTH];
                adderB = acc[0] ? mcand : '0;
                if (lastIter) begin
`ifdef SEQ_MULT_SIGNED_EN
                    stateNext = runToDone ? DONE : NEG_LO;
`else
                    stateNext = DONE;
`endif
                end
            end
            DONE: stateNext = IDLE;
`ifdef SEQ_MULT_SIGNED_EN
            ABS_A: begin
                adderA    = ~mcand;
                adderCin  = 1'b1;
                stateNext = ABS_B;
            end
            ABS_B: begin
                adderA    = ~acc[WIDTH-1:0];
                adderCin  = 1'b1;
                stateNext = RUN;
            end
            NEG_LO: begin
                adderA    = ~acc[WIDTH-1:0];
                adderCin  = 1'b1;
                stateNext = NEG_HI;
            end
            NEG_HI: begin
                // ~hi + 1 only when the low-word negation carried out, i.e. lo was zero.
                adderA    = ~acc[2*WIDTH-1:WIDTH];
                adderCin  = loWasZero;
                stateNext = DONE;
            end
`endif
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            acc     <= '0;
            product <= '0;
            cnt     <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            signedOp  <= 1'b0;
            negSign   <= 1'b0;
            loWasZero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a;
                        acc   <= {{WIDTH{1'b0}}, b};
                        cnt   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                        signedOp  <= is_signed;
                        negSign   <= 1'b0;
                        loWasZero <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    acc <= runAcc;
                    cnt <= cnt + CNT_W'(1);
                    if (lastIter && runToDone) product <= runAcc;
                end
`ifdef SEQ_MULT_SIGNED_EN
                ABS_A: begin
                    if (mcand[WIDTH-1]) mcand <= adderS;
                    negSign <= mcand[WIDTH-1] ^ acc[WIDTH-1];
                end
                ABS_B: begin
                    if (acc[WIDTH-1]) acc[WIDTH-1:0] <= adderS;
                end
                NEG_LO: begin
                    loWasZero <= (acc[WIDTH-1:0] == '0);
                    if (negSign) acc[WIDTH-1:0] <= adderS;
                end
                NEG_HI: begin
                    if (negSign) begin
                        acc[2*WIDTH-1:WIDTH] <= adderS;
                        product <= {adderS, acc[WIDTH-1:0]};
                    end else begin
                        product <= acc;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: doc/seq_mult_32.md
Name: seq_mult_32

Overview:
- Iterative shift-add 32x32 multiplier for the single-cycle datapath's multiply path.
- Sits directly downstream of the 32-bit ripple adder (adder_32): it instantiates one adder_32, drives its A/B/CarryIn every cycle, and consumes S to build a 64-bit product.
- Start/busy/done handshake to the control unit.
- Result exposed as product_hi/product_lo.

Parameters:
- WIDTH, 32, operand width. Fixed to match adder_32; other values unsupported.
- CNT_W, 6, iteration counter width. Must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  32  multiplicand, captured on accepted start
- b  input  32  multiplier, captured on accepted start
- busy  output  1  high while an operation is in flight, including the DONE cycle
- done  output  1  one-cycle pulse; product valid
- product_hi  output  32  upper product word
- product_lo  output  32  lower product word

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, product_hi=0, product_lo=0, counter=0, internal registers=0.
- Reset mid-operation aborts immediately: no done pulse, outputs return to 0.
- States (unsigned): IDLE -> RUN -> DONE -> IDLE.
- IDLE, start=1: latch mcand=a, acc={32'h0, b}, cnt=0; go to RUN.
- RUN, 32 cycles:
  - Adder inputs: A=acc[63:32], B = acc[0] ? mcand : 32'h0, CarryIn=0.
  - Carry-out derived as (A31&B31)|((A31|B31)&~S31).
  - acc <= {cout, S, acc[31:1]}; cnt++.
  - After the cnt=31 iteration, go to DONE.
- DONE, 1 cycle: done=1, product_hi/lo <= final acc; go to IDLE.
- Timing (start high in cycle 0, state IDLE): busy=1 in cycles 1-33; done=1 in cycle 33. Earliest next start accepted in cycle 34.
- start while busy=1 (including DONE): ignored, no queuing.
- start held high continuously: a new operation is accepted each time busy returns to 0.
- product_hi/lo change only on DONE entry and otherwise hold the last result across idle cycles and new starts.
- Result is the exact 64-bit unsigned product, with no truncation or overflow flag.
- Boundary cases:
  - a=0 or b=0: full latency still applies.
  - All-ones operands: carry-out must propagate every iteration.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined:
  - Adds input port is_signed (1 bit), captured with start.
  - is_signed=1 path: IDLE -> ABS_A -> ABS_B -> RUN(32) -> NEG_LO -> NEG_HI -> DONE.
  - ABS_A / ABS_B: negate a / b through the shared adder_32 (A=~x, B=0, CarryIn=1) when the operand MSB=1; pass through otherwise. Record sign = a31^b31.
  - NEG_LO: if sign, lo = ~lo + 1 via adder. NEG_HI: hi = ~hi + (lo_was_zero).
  - ABS and NEG cycles always spent, so signed latency is fixed: busy cycles 1-37, done in cycle 37.
  - is_signed=0 behaves exactly as the unsigned build, with latency 33.
- Undefined: no is_signed port, unsigned only, none of these states are synthesized.

Test Plan:
- Reset, then a=3, b=5, start in cycle 0 -> busy 1-33, done pulse cycle 33, hi=0x00000000, lo=0x0000000F.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at cycle 33; values held through 10 idle cycles.
- Start a=7, b=6; pulse start with a=2, b=2 in cycle 5 -> second request ignored. Result lo=0x2A; no second done unless start is reasserted after busy falls.
- Start a=0x12345678, b=0x9ABCDEF0; reset in cycle 10 -> from cycle 11 busy=0, done=0, hi/lo=0; no done pulse ever appears.
- Back-to-back: start held high -> done in cycles 33 and 67, second op accepted in cycle 34.
- SEQ_MULT_SIGNED_EN, is_signed=1, a=0xFFFFFFFD (-3), b=5 -> done cycle 37, hi=0xFFFFFFFF, lo=0xFFFFFFF1. Also a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
